// File: rtl/cfo_phase_accum.sv
// ============================================================================
// Module  : cfo_phase_accum
// Brief   : Tags each sample of a packet with phase k*increment for the CFO
//           rotator, behind a 2-entry skid buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cfo_phase_accum #(
  parameter int PHASE_WIDTH  = 32,
  parameter int SAMPLE_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                freq_valid,
  output logic                                freq_ready,
  input  logic [PHASE_WIDTH-1:0]              freq_data,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [SAMPLE_WIDTH-1:0]             s_data,
  input  logic                                s_last,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [PHASE_WIDTH+SAMPLE_WIDTH-1:0] m_data,
  output logic                                m_last
);

  localparam int WORD_WIDTH = PHASE_WIDTH + SAMPLE_WIDTH;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] inc_q, inc_d;
  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic                   alive_q;
  logic                   rdy_q, rdy_d;
  logic                   out_valid_q, out_valid_d;
  logic [WORD_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [WORD_WIDTH-1:0]  skid_data_q, skid_data_d;
  logic                   skid_last_q, skid_last_d;

  logic                   in_idle;
  logic                   freq_fire;
  logic                   s_fire;
  logic                   pop;
  logic [WORD_WIDTH-1:0]  in_word;

  // A pending increment load in IDLE takes priority over the first sample.
  assign in_idle    = (state_q == IDLE);
  assign freq_ready = alive_q && in_idle;
  assign s_ready    = rdy_q && !(in_idle && freq_valid);
  assign freq_fire  = freq_valid && freq_ready;
  assign s_fire     = s_valid && s_ready;
  assign pop        = out_valid_q && m_ready;
  assign in_word    = {acc_q, s_data};

  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;
  assign m_last  = out_last_q;

  always_comb begin
    state_d      = state_q;
    inc_d        = inc_q;
    acc_d        = acc_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;

    if (freq_fire) begin
      inc_d = freq_data;
    end

    if (s_fire) begin
      if (s_last) begin
        acc_d   = '0;
        state_d = IDLE;
      end else begin
        acc_d   = acc_q + inc_q;
        state_d = BUSY;
      end
    end

    // While the skid holds data s_ready is low, so only draining can happen.
    if (skid_valid_q) begin
      if (pop) begin
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = 1'b0;
      end
    end else if (!out_valid_q || pop) begin
      out_valid_d = s_fire;
      if (s_fire) begin
        out_data_d = in_word;
        out_last_d = s_last;
      end
    end else if (s_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_word;
      skid_last_d  = s_last;
    end

    rdy_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      inc_q        <= '0;
      acc_q        <= '0;
      alive_q      <= 1'b0;
      rdy_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      inc_q        <= inc_d;
      acc_q        <= acc_d;
      alive_q      <= 1'b1;
      rdy_q        <= rdy_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cfo_phase_accum.sv
// ============================================================================
// Module  : tb_cfo_phase_accum
// Brief   : Directed and randomized checks of cfo_phase_accum against a
//           phase = index * increment reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cfo_phase_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        freq_valid;
  logic        freq_ready;
  logic [31:0] freq_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_last;

  always #5 clk = ~clk;

  cfo_phase_accum #(.PHASE_WIDTH(32), .SAMPLE_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .freq_valid (freq_valid),
    .freq_ready (freq_ready),
    .freq_data  (freq_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  int          chk = 0;
  int          err = 0;

  // Model: {last, phase, data} entries in flight, current increment, index k.
  logic [64:0] exp_q[$];
  logic [64:0] obs_q[$];
  logic [31:0] mdl_inc;
  int          mdl_k;
  bit          mdl_alive;
  int          mr_mode;
  int          mr_cnt;
  bit          prev_stall;
  logic [63:0] prev_data;
  bit          last_s_acc;
  bit          last_f_acc;

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    chk++;
    assert (o === e) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic timeout(input string tag);
    chk++;
    err++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  task automatic cycle();
    bit idle, e_fr, e_sr, e_mv, f_acc, s_acc, pop;
    @(negedge clk);
    idle = (mdl_k == 0);
    e_fr = mdl_alive && idle;
    e_sr = mdl_alive && (exp_q.size() != 2) && !(idle && freq_valid);
    e_mv = (exp_q.size() != 0);
    check("freq_ready", 64'(freq_ready), 64'(e_fr));
    check("s_ready", 64'(s_ready), 64'(e_sr));
    check("m_valid", 64'(m_valid), 64'(e_mv));
    if (e_mv) begin
      check("m_data", m_data, exp_q[0][63:0]);
      check("m_last", 64'(m_last), 64'(exp_q[0][64]));
    end
    if (prev_stall) check("stall_hold", m_data, prev_data);
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    f_acc = freq_valid && e_fr;
    s_acc = s_valid && e_sr;
    pop   = e_mv && m_ready;
    if (pop) obs_q.push_back({m_last, m_data});
    @(posedge clk);
    mdl_alive = reset;
    if (pop) void'(exp_q.pop_front());
    if (s_acc) begin
      exp_q.push_back({s_last, mdl_inc * 32'(mdl_k), s_data});
      mdl_k = s_last ? 0 : mdl_k + 1;
    end
    if (f_acc) mdl_inc = freq_data;
    last_s_acc = s_acc;
    last_f_acc = f_acc;
    #1;
    if (f_acc) freq_valid = 1'b0;
    case (mr_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ((mr_cnt % 4) == 0) || ((mr_cnt % 4) == 3);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    mr_cnt++;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_data", m_data, 64'(0));
    check("rst_m_last", 64'(m_last), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_freq_ready", 64'(freq_ready), 64'(0));
    exp_q.delete();
    mdl_inc    = '0;
    mdl_k      = 0;
    mdl_alive  = 1'b0;
    prev_stall = 1'b0;
    s_valid    = 1'b0;
    freq_valid = 1'b0;
    s_last     = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic load_freq(input logic [31:0] v);
    int n;
    freq_valid = 1'b1;
    freq_data  = v;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_f_acc && n < 100);
    if (!last_f_acc) timeout("load_freq");
    freq_valid = 1'b0;
  endtask

  // dsel: 0 constant dval, 1 sample index, 2 random.
  task automatic send_pkt(input int n, input int gapmax, input int freq_at,
                          input logic [31:0] fval, input int dsel, input logic [31:0] dval);
    int b;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, gapmax)) cycle();
      if (i == freq_at) begin
        freq_valid = 1'b1;
        freq_data  = fval;
      end
      s_valid = 1'b1;
      s_data  = (dsel == 0) ? dval : (dsel == 1) ? 32'(i) : $urandom;
      s_last  = (i == n - 1);
      b = 0;
      do begin
        cycle();
        b++;
      end while (!last_s_acc && b < 100);
      if (!last_s_acc) timeout("send_sample");
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      cycle();
      b++;
    end
    if (exp_q.size() != 0) timeout("drain");
    cycle();
  endtask

  task automatic check_phases(input string tag, input int first, input logic [31:0] ph[]);
    for (int i = 0; i < ph.size(); i++) begin
      if (obs_q.size() > first + i) check(tag, 64'(obs_q[first + i][63:32]), 64'(ph[i]));
      else timeout(tag);
    end
  endtask

  initial begin
    reset      = 1'b0;
    freq_valid = 1'b0;
    freq_data  = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    m_ready    = 1'b1;
    mr_mode    = 0;
    mr_cnt     = 0;
    mdl_inc    = '0;
    mdl_k      = 0;
    mdl_alive  = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    apply_reset();
    cycle();

    // Basic phase ramp at pi/4 steps.
    obs_q.delete();
    load_freq(32'h2000_0000);
    send_pkt(4, 0, -1, '0, 0, 32'h4000_4000);
    drain();
    check_phases("ramp_phase", 0, '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h6000_0000});
    if (obs_q.size() >= 4) begin
      check("ramp_low", obs_q[1][31:0], 64'h4000_4000);
      check("ramp_last3", 64'(obs_q[2][64]), 64'(0));
      check("ramp_last4", 64'(obs_q[3][64]), 64'(1));
    end else timeout("ramp_count");

    // Wrap modulo 2^32 and restart at each packet boundary.
    obs_q.delete();
    load_freq(32'hC000_0000);
    send_pkt(3, 0, -1, '0, 2, '0);
    send_pkt(2, 0, -1, '0, 2, '0);
    drain();
    check_phases("wrap_phase", 0, '{32'h0, 32'hC000_0000, 32'h8000_0000, 32'h0, 32'hC000_0000});

    // Backpressure with m_ready pattern 1,0,0,1.
    obs_q.delete();
    load_freq(32'h1);
    mr_mode = 1;
    mr_cnt  = 0;
    send_pkt(16, 0, -1, '0, 1, '0);
    drain();
    mr_mode = 0;
    check("bp_count", 64'(obs_q.size()), 64'(16));
    for (int i = 0; i < 16 && i < obs_q.size(); i++)
      check("bp_word", obs_q[i][63:0], {32'(i), 32'(i)});

    // Increment load held off mid-packet, applied to the next packet.
    obs_q.delete();
    load_freq(32'h0800_0000);
    send_pkt(4, 0, 1, 32'h1000_0000, 2, '0);
    drain();
    send_pkt(3, 0, -1, '0, 2, '0);
    drain();
    check_phases("lock_phase", 0, '{32'h0, 32'h0800_0000, 32'h1000_0000, 32'h1800_0000,
                                    32'h0, 32'h1000_0000, 32'h2000_0000});

    // Simultaneous freq and sample in IDLE: frequency first.
    obs_q.delete();
    freq_valid = 1'b1;
    freq_data  = 32'h0300_0000;
    s_valid    = 1'b1;
    s_data     = 32'h1234_5678;
    s_last     = 1'b1;
    cycle();
    check("simul_first", {62'b0, last_f_acc, last_s_acc}, 64'b10);
    cycle();
    check("simul_second", {63'b0, last_s_acc}, 64'b1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    drain();
    if (obs_q.size() > 0) check("simul_word", obs_q[0][63:0], 64'h0000_0000_1234_5678);
    else timeout("simul_word");

    // Reset after two of five samples; increment cleared afterwards.
    obs_q.delete();
    load_freq(32'h0500_0000);
    m_ready = 1'b0;
    mr_mode = 3;
    s_last  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = 32'(i);
      cycle();
    end
    s_valid = 1'b0;
    apply_reset();
    mr_mode = 0;
    cycle();
    obs_q.delete();
    send_pkt(4, 1, -1, '0, 2, '0);
    drain();
    check_phases("post_rst_phase", 0, '{32'h0, 32'h0, 32'h0, 32'h0});

    // Single-sample packet.
    obs_q.delete();
    load_freq(32'h4000_0000);
    send_pkt(1, 0, -1, '0, 0, 32'hABCD_0001);
    drain();
    if (obs_q.size() > 0) check("single_word", {31'b0, obs_q[0]}, {31'b0, 1'b1, 32'h0, 32'hABCD_0001});
    else timeout("single_word");
    check("single_freq_ready", 64'(freq_ready), 64'(1));

    // Randomized packets, increments, gaps and backpressure.
    mr_mode = 2;
    for (int p = 0; p < 8; p++) begin
      load_freq($urandom);
      send_pkt($urandom_range(1, 9), 2, ($urandom_range(0, 3) == 0) ? 1 : -1, $urandom, 2, '0);
    end
    mr_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

`default_nettype wire
